// File: rtl/part_2_upload_packer.sv
// part_2_upload_packer
// Upstream stage of the target-side export path. Samples the partition outputs
// {valid, o_data} once per rising edge of the mission clock level clk_0_h, as
// seen from the utility clock. Each sample gets a sequence tag and is queued in
// a small FIFO, which is presented to the transactor over valid/ready.
//
// Ports
//   clk_i, rst_i      utility clock, synchronous active-high reset
//   clk_0_h           mission clock level, sampled on clk_i
//   freeze_i          while high, mission edges are ignored (lost, not deferred)
//   valid, o_data     partition outputs forming the captured vector
//   flush_i           single-cycle pulse that empties the FIFO
//   vec_o, vec_seq_o  head vector {valid, o_data} and its sequence tag
//   vec_valid_o       FIFO is not empty
//   vec_ready_i       transactor accepts the head entry
//   fifo_level_o      occupancy 0..DEPTH
//   overflow_o        sticky: a capture was dropped on a full FIFO
//   drop_cnt_o        saturating count of dropped captures
module part_2_upload_packer #(
    parameter int DEPTH       = 8,
    parameter int DATA_W      = 8,
    parameter int CAPTURE_ALL = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clk_0_h,
    input  logic                     freeze_i,
    input  logic                     valid,
    input  logic [DATA_W-1:0]        o_data,
    input  logic                     flush_i,
    output logic [DATA_W:0]          vec_o,
    output logic [7:0]               vec_seq_o,
    output logic                     vec_valid_o,
    input  logic                     vec_ready_i,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     overflow_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W:0]    vec_mem [DEPTH];
    logic [7:0]         seq_mem [DEPTH];

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [7:0]         seq;
    logic               clk_0_h_d;
    logic               first_cap;
    logic [DATA_W:0]    last_vec;

    logic [DATA_W:0]    cur_vec;
    logic               mission_edge;
    logic               differs;
    logic               capture;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;

    always_comb begin
        cur_vec      = {valid, o_data};
        // A capture in the flush cycle is suppressed by masking the edge itself.
        mission_edge = clk_0_h & ~clk_0_h_d & ~freeze_i & ~flush_i;
        differs      = first_cap | (cur_vec != last_vec);
        capture      = mission_edge & ((CAPTURE_ALL != 0) | differs);
        full         = (level == LVL_W'(DEPTH));
        pop          = (level != '0) & vec_ready_i;
        // When full, a same-cycle pop frees the slot the push needs.
        push         = capture & (~full | pop);
        drop         = capture & full & ~pop;
    end

    // Control state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Held at 1 so clk_0_h already high out of reset is not an edge.
            clk_0_h_d  <= 1'b1;
            first_cap  <= 1'b1;
            seq        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            clk_0_h_d <= clk_0_h;
            if (capture) begin
                first_cap <= 1'b0;
                seq       <= seq + 8'd1;
            end
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != 16'hFFFF)
                    drop_cnt_o <= drop_cnt_o + 16'd1;
            end
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end
    end

    // Data storage; last_vec only matters once first_cap has cleared.
    always_ff @(posedge clk_i) begin
        if (capture)
            last_vec <= cur_vec;
        if (push) begin
            vec_mem[wr_ptr] <= cur_vec;
            seq_mem[wr_ptr] <= seq;
        end
    end

    // Head is forced to zero when empty so stale entries never show.
    always_comb begin
        vec_valid_o  = (level != '0);
        vec_o        = vec_valid_o ? vec_mem[rd_ptr] : '0;
        vec_seq_o    = vec_valid_o ? seq_mem[rd_ptr] : '0;
        fifo_level_o = level;
    end

endmodule

// File: tb/tb_part_2_upload_packer.sv
// Testbench for part_2_upload_packer. Two instances share all inputs: u0 with
// CAPTURE_ALL=1 and u1 with CAPTURE_ALL=0. A queue-based reference model
// predicts every output of both instances each cycle; directed scenarios add
// explicit checks of the headline values, followed by a randomized phase.
module tb_part_2_upload_packer;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clk0, frz, vld, flush, rdy;
    logic [7:0]  dat;

    logic [8:0]  vec0, vec1;
    logic [7:0]  sq0, sq1;
    logic        vv0, vv1, of0, of1;
    logic [3:0]  lv0, lv1;
    logic [15:0] dc0, dc1;

    part_2_upload_packer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CAPTURE_ALL(1)) u0 (
        .clk_i(clk), .rst_i(rst), .clk_0_h(clk0), .freeze_i(frz), .valid(vld),
        .o_data(dat), .flush_i(flush), .vec_o(vec0), .vec_seq_o(sq0),
        .vec_valid_o(vv0), .vec_ready_i(rdy), .fifo_level_o(lv0),
        .overflow_o(of0), .drop_cnt_o(dc0));

    part_2_upload_packer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CAPTURE_ALL(0)) u1 (
        .clk_i(clk), .rst_i(rst), .clk_0_h(clk0), .freeze_i(frz), .valid(vld),
        .o_data(dat), .flush_i(flush), .vec_o(vec1), .vec_seq_o(sq1),
        .vec_valid_o(vv1), .vec_ready_i(rdy), .fifo_level_o(lv1),
        .overflow_o(of1), .drop_cnt_o(dc1));

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Reference model: entries are {seq[7:0], vec[8:0]}.
    logic [16:0] mq [2][$];
    int          m_seq   [2];
    bit          m_first [2];
    logic [8:0]  m_last  [2];
    bit          m_ovf   [2];
    int          m_drop  [2];
    bit          m_prev;

    task automatic model_step();
        logic [8:0] v;
        bit         seen, cap, pop;
        int         sz;
        v    = {vld, dat};
        seen = clk0 && !m_prev && !frz && !flush;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                m_seq[k]   = 0;
                m_first[k] = 1'b1;
                m_ovf[k]   = 1'b0;
                m_drop[k]  = 0;
            end else begin
                sz  = mq[k].size();
                pop = (sz > 0) && rdy;
                cap = seen && (k == 0 || m_first[k] || v != m_last[k]);
                if (flush) mq[k].delete();
                else if (pop) mq[k].delete(0);
                if (cap) begin
                    m_first[k] = 1'b0;
                    m_last[k]  = v;
                    if (sz < DEPTH || pop) mq[k].push_back({8'(m_seq[k]), v});
                    else begin
                        m_ovf[k] = 1'b1;
                        if (m_drop[k] < 65535) m_drop[k]++;
                    end
                    m_seq[k] = (m_seq[k] + 1) % 256;
                end
            end
        end
        m_prev = rst ? 1'b1 : clk0;
    endtask

    task automatic compare();
        logic [16:0] h;
        int          sz;
        for (int k = 0; k < 2; k++) begin
            sz = mq[k].size();
            h  = (sz > 0) ? mq[k][0] : 17'd0;
            check($sformatf("u%0d.vec_valid", k), 32'(k == 0 ? vv0 : vv1), 32'(sz > 0));
            check($sformatf("u%0d.vec", k),       32'(k == 0 ? vec0 : vec1), 32'(h[8:0]));
            check($sformatf("u%0d.seq", k),       32'(k == 0 ? sq0 : sq1), 32'(h[16:9]));
            check($sformatf("u%0d.level", k),     32'(k == 0 ? lv0 : lv1), 32'(sz));
            check($sformatf("u%0d.overflow", k),  32'(k == 0 ? of0 : of1), 32'(m_ovf[k]));
            check($sformatf("u%0d.drop_cnt", k),  32'(k == 0 ? dc0 : dc1), 32'(m_drop[k]));
        end
    endtask

    task automatic cyc(input logic c, input logic v, input logic [7:0] d,
                       input logic r, input logic fz, input logic fl);
        clk0 = c; vld = v; dat = d; rdy = r; frz = fz; flush = fl;
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    // clk_0_h is held high across reset on purpose.
    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // One mission clock period: low cycle (no pop), then the rising cycle.
    task automatic medge(input logic v, input logic [7:0] d, input logic r);
        cyc(1'b0, v, d, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, v, d, r, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; clk0 = 1'b1; frz = 1'b0; vld = 1'b0; flush = 1'b0; rdy = 1'b0; dat = 8'h00;
        m_prev = 1'b1;

        // Reset state, clk_0_h high through reset release
        do_reset();
        check("reset.level", 32'(lv0), 32'd0);
        check("reset.vec", 32'(vec0), 32'd0);
        check("reset.drop", 32'(dc0), 32'd0);
        cyc(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        check("hold_high.level", 32'(lv0), 32'd0);

        // Basic capture and latency
        medge(1'b1, 8'hA5, 1'b1);
        check("basic.valid", 32'(vv0), 32'd1);
        check("basic.vec", 32'(vec0), 32'h1A5);
        check("basic.seq", 32'(sq0), 32'd0);
        medge(1'b1, 8'h3C, 1'b1);
        check("basic2.vec", 32'(vec0), 32'h13C);
        check("basic2.seq", 32'(sq0), 32'd1);

        // Overflow: 10 edges into 8 entries
        do_reset();
        for (int i = 0; i < 10; i++) medge(1'b1, 8'(i + 16), 1'b0);
        check("ovf.level", 32'(lv0), 32'd8);
        check("ovf.flag", 32'(of0), 32'd1);
        check("ovf.drops", 32'(dc0), 32'd2);
        for (int i = 0; i < 8; i++) begin
            check("drain.seq", 32'(sq0), 32'(i));
            check("drain.vec", 32'(vec0), 32'({1'b1, 8'(i + 16)}));
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        check("drain.empty", 32'(vv0), 32'd0);

        // Full with simultaneous pop and push
        do_reset();
        for (int i = 0; i < 8; i++) medge(1'b1, 8'(i + 8'h40), 1'b0);
        medge(1'b1, 8'h77, 1'b1);
        check("fullpp.level", 32'(lv0), 32'd8);
        check("fullpp.drops", 32'(dc0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("fullpp.seq", 32'(sq0), 32'(i + 1));
            if (i == 7) check("fullpp.tail", 32'(vec0), 32'h177);
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end

        // Compression on u1
        do_reset();
        medge(1'b1, 8'hA5, 1'b0);
        medge(1'b1, 8'hA5, 1'b0);
        medge(1'b1, 8'hA5, 1'b0);
        medge(1'b0, 8'hA5, 1'b0);
        check("comp.level", 32'(lv1), 32'd2);
        check("comp.seq0", 32'(sq1), 32'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("comp.seq1", 32'(sq1), 32'd1);
        check("comp.vec1", 32'(vec1), 32'h0A5);
        do_reset();
        medge(1'b0, 8'h00, 1'b0);
        check("comp.first_zero", 32'(lv1), 32'd1);

        // Flush with 5 queued
        do_reset();
        for (int i = 0; i < 5; i++) medge(1'b1, 8'(i), 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("flush.level", 32'(lv0), 32'd0);
        check("flush.valid", 32'(vv0), 32'd0);
        medge(1'b1, 8'h99, 1'b0);
        check("flush.next_seq", 32'(sq0), 32'd5);
        // Edge coinciding with flush is suppressed
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1);
        check("flush_edge.level", 32'(lv0), 32'd0);

        // Freeze across an edge
        do_reset();
        cyc(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        check("freeze.level", 32'(lv0), 32'd0);

        // Sequence wrap over 257 captures
        do_reset();
        for (int i = 0; i < 257; i++) begin
            medge(1'b1, 8'(i), 1'b1);
            if (i == 255) check("wrap.seq255", 32'(sq0), 32'd255);
            if (i == 256) check("wrap.seq0", 32'(sq0), 32'd0);
        end

        // Randomized phase
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            cyc(($urandom_range(0, 2) == 0) ? ~clk0 : clk0,
                1'($urandom), 8'($urandom_range(0, 3)),
                1'($urandom_range(0, 2) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 39) == 0));
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
